// File: rtl/cpu_defs_pkg.sv
// Shared encodings for writeback source select, link mode and load type.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package cpu_defs_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM  = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;
   localparam logic [1:0] WB_SEL_AUX  = 2'b11;

   localparam logic [1:0] LINK_NONE     = 2'b00;
   localparam logic [1:0] LINK_ALWAYS   = 2'b01;
   localparam logic [1:0] LINK_IF_COND  = 2'b10;
   localparam logic [1:0] LINK_IF_NCOND = 2'b11;

   localparam logic [2:0] LD_WORD = 3'b000;
   localparam logic [2:0] LD_LB   = 3'b001;
   localparam logic [2:0] LD_LBU  = 3'b010;
   localparam logic [2:0] LD_LH   = 3'b011;
   localparam logic [2:0] LD_LHU  = 3'b100;

   // Control half of a WB entry; the DATA_W-wide payloads live beside it.
   typedef struct packed {
      logic       valid;
      logic [1:0] wb_sel;
      logic [1:0] link_mode;
      logic       cond;
      logic [4:0] dst;
      logic       regwrite;
      logic [2:0] ld_type;
      logic [1:0] addr_lo;
   } wb_meta_t;

   // Link is taken always, on a true condition, or on a false condition.
   function automatic logic link_taken(input logic [1:0] mode, input logic cond);
      return (mode == LINK_ALWAYS) ||
             ((mode == LINK_IF_COND) && cond) ||
             ((mode == LINK_IF_NCOND) && !cond);
   endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Byte/half selection and sign/zero extension of load data (WB_LOAD_EXT_EN enables it).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module wb_load_ext
   import cpu_defs_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] mem,
   input  logic [2:0]        ld_type,
   input  logic [1:0]        addr_lo,
   output logic [DATA_W-1:0] data
);

`ifdef WB_LOAD_EXT_EN
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte/half, then extend; reserved types behave as word.
   always_comb begin
      byte_sel = mem[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? mem[31:16] : mem[15:0];
      case (ld_type)
         LD_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LD_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LD_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
         default: data = mem;
      endcase
   end
`else
   // Load type and address bits are accepted but have no effect here.
   logic unused_ld;
   assign unused_ld = ^{ld_type, addr_lo};
   assign data      = mem;
`endif

endmodule

// File: rtl/wb_select_pipe.sv
// MEM->WB pipeline register with writeback source mux, link values and retire counter (WB_LOAD_EXT_EN adds load extension).
// Latency: 1 cycle from m_* inputs to w_* outputs.
// Backpressure: stall holds the entry and counter; flush (higher priority) loads a bubble.
module wb_select_pipe
   import cpu_defs_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int LINK_OFF = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              m_valid,
   input  logic [DATA_W-1:0] m_pc,
   input  logic [DATA_W-1:0] m_alu,
   input  logic [DATA_W-1:0] m_mem,
   input  logic [DATA_W-1:0] m_aux,
   input  logic [1:0]        m_wb_sel,
   input  logic [1:0]        m_link_mode,
   input  logic              m_cond,
   input  logic [4:0]        m_dst,
   input  logic              m_regwrite,
   input  logic [2:0]        m_ld_type,
   input  logic [1:0]        m_addr_lo,
   output logic [DATA_W-1:0] w_data,
   output logic [4:0]        w_dst,
   output logic              w_we,
   output logic [DATA_W-1:0] w_pc,
   output logic              w_valid,
   output logic [31:0]       retire_cnt
);

   wb_meta_t          meta_q;
   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] aux_q;
   logic [31:0]       cnt_q;
   logic [DATA_W-1:0] mem_ext;
   logic              link_act;

   // WB entry: flush beats stall; otherwise capture everything, valid included.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         pc_q   <= '0;
         alu_q  <= '0;
         mem_q  <= '0;
         aux_q  <= '0;
      end else if (flush) begin
         meta_q <= '0;
         pc_q   <= '0;
         alu_q  <= '0;
         mem_q  <= '0;
         aux_q  <= '0;
      end else if (!stall) begin
         meta_q.valid     <= m_valid;
         meta_q.wb_sel    <= m_wb_sel;
         meta_q.link_mode <= m_link_mode;
         meta_q.cond      <= m_cond;
         meta_q.dst       <= m_dst;
         meta_q.regwrite  <= m_regwrite;
         meta_q.ld_type   <= m_ld_type;
         meta_q.addr_lo   <= m_addr_lo;
         pc_q             <= m_pc;
         alu_q            <= m_alu;
         mem_q            <= m_mem;
         aux_q            <= m_aux;
      end
   end

   // Count only real captures of a valid instruction; wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (!flush && !stall && m_valid) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   wb_load_ext #(
      .DATA_W (DATA_W)
   ) u_load_ext (
      .mem     (mem_q),
      .ld_type (meta_q.ld_type),
      .addr_lo (meta_q.addr_lo),
      .data    (mem_ext)
   );

   // Writeback mux: a taken link overrides the source select; an untaken
   // conditional link also suppresses the write.
   always_comb begin
      link_act = link_taken(meta_q.link_mode, meta_q.cond);
      if (link_act) begin
         w_data = pc_q + DATA_W'(LINK_OFF);
      end else begin
         case (meta_q.wb_sel)
            WB_SEL_ALU: w_data = alu_q;
            WB_SEL_MEM: w_data = mem_ext;
            WB_SEL_AUX: w_data = aux_q;
            default:    w_data = '0;
         endcase
      end
      if (meta_q.link_mode[1] && !link_act) begin
         w_we = 1'b0;
      end else begin
         w_we = meta_q.valid && meta_q.regwrite && (meta_q.dst != 5'd0);
      end
   end

   assign w_dst      = meta_q.dst;
   assign w_pc       = pc_q;
   assign w_valid    = meta_q.valid;
   assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Self-checking bench for wb_select_pipe against a behavioural writeback model.
// Latency: expects outputs one clock after capture.
// Backpressure: exercises stall, flush and their combination.
module tb_wb_select_pipe;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              stall, flush, m_valid, m_cond, m_regwrite;
   logic [DATA_W-1:0] m_pc, m_alu, m_mem, m_aux;
   logic [1:0]        m_wb_sel, m_link_mode, m_addr_lo;
   logic [4:0]        m_dst;
   logic [2:0]        m_ld_type;
   logic [DATA_W-1:0] w_data, w_pc;
   logic [4:0]        w_dst;
   logic              w_we, w_valid;
   logic [31:0]       retire_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        valid;
      logic [31:0] pc, alu, mem, aux;
      logic [1:0]  sel, mode, alo;
      logic        cond, rw;
      logic [4:0]  dst;
      logic [2:0]  ld;
   } ent_t;

   ent_t        e;
   logic [31:0] exp_cnt;

   always #5 clk = ~clk;

   wb_select_pipe #(.DATA_W(DATA_W), .LINK_OFF(8)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_pc(m_pc), .m_alu(m_alu), .m_mem(m_mem), .m_aux(m_aux),
      .m_wb_sel(m_wb_sel), .m_link_mode(m_link_mode), .m_cond(m_cond), .m_dst(m_dst),
      .m_regwrite(m_regwrite), .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
      .w_data(w_data), .w_dst(w_dst), .w_we(w_we), .w_pc(w_pc), .w_valid(w_valid),
      .retire_cnt(retire_cnt)
   );

   // Reference load result: byte/half by shifting, sign by adding the high ones.
   function automatic logic [31:0] model_load(input logic [31:0] mem, input logic [2:0] ld,
                                              input logic [1:0] alo);
`ifdef WB_LOAD_EXT_EN
      logic [31:0] b, h;
      b = (mem >> (8 * alo)) & 32'h0000_00FF;
      h = (mem >> (16 * alo[1])) & 32'h0000_FFFF;
      case (ld)
         3'd1: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
         3'd2: return b;
         3'd3: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd4: return h;
         default: return mem;
      endcase
`else
      if (ld == 3'd7 && alo == 2'd3) return mem;
      return mem;
`endif
   endfunction

   function automatic logic model_link(input ent_t x);
      case (x.mode)
         2'd1:    return 1'b1;
         2'd2:    return x.cond;
         2'd3:    return !x.cond;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_data(input ent_t x);
      if (model_link(x)) return x.pc + 32'd8;
      case (x.sel)
         2'd0:    return x.alu;
         2'd1:    return model_load(x.mem, x.ld, x.alo);
         2'd3:    return x.aux;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic model_we(input ent_t x);
      if (x.mode >= 2'd2 && !model_link(x)) return 1'b0;
      return x.valid && x.rw && (x.dst != 5'd0);
   endfunction

   task automatic model_clear();
      e = '{valid: 1'b0, pc: '0, alu: '0, mem: '0, aux: '0, sel: '0, mode: '0,
            alo: '0, cond: 1'b0, rw: 1'b0, dst: '0, ld: '0};
   endtask

   task automatic clear_inputs();
      stall = 0; flush = 0; m_valid = 0; m_cond = 0; m_regwrite = 0;
      m_pc = 0; m_alu = 0; m_mem = 0; m_aux = 0;
      m_wb_sel = 0; m_link_mode = 0; m_addr_lo = 0; m_dst = 0; m_ld_type = 0;
   endtask

   // One clock: update the model with the inputs seen at the edge, then move
   // to the falling edge where outputs are sampled and new inputs driven.
   task automatic tick();
      @(posedge clk);
      if (flush) begin
         model_clear();
      end else if (!stall) begin
         e.valid = m_valid; e.pc = m_pc; e.alu = m_alu; e.mem = m_mem; e.aux = m_aux;
         e.sel = m_wb_sel; e.mode = m_link_mode; e.cond = m_cond; e.dst = m_dst;
         e.rw = m_regwrite; e.ld = m_ld_type; e.alo = m_addr_lo;
         if (m_valid) exp_cnt = exp_cnt + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      model_clear();
      exp_cnt = 0;
      #1;
      checks++;
      if ({w_data, w_dst, w_we, w_pc, w_valid, retire_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: data=%h dst=%0d we=%b pc=%h valid=%b cnt=%0d, all should be 0",
                  w_data, w_dst, w_we, w_pc, w_valid, retire_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_alu_write();
      m_valid = 1; m_regwrite = 1; m_dst = 8; m_wb_sel = 2'b00; m_alu = 32'h1234;
      tick();
      checks++;
      if (w_data !== 32'h1234 || w_dst !== 5'd8 || w_we !== 1'b1 || retire_cnt !== 32'd1) begin
         errors++;
         $display("FAIL alu_write: data=%h dst=%0d we=%b cnt=%0d, want 1234 8 1 1",
                  w_data, w_dst, w_we, retire_cnt);
      end
   endtask

   task automatic test_cond_link();
      clear_inputs();
      m_valid = 1; m_regwrite = 1; m_pc = 32'h3000; m_link_mode = 2'b10; m_cond = 1;
      m_dst = 31; m_wb_sel = 2'b10;
      tick();
      checks++;
      if (w_data !== 32'h3008 || w_we !== 1'b1 || retire_cnt !== 32'd2) begin
         errors++;
         $display("FAIL cond_link_taken: data=%h we=%b cnt=%0d, want 3008 1 2", w_data, w_we, retire_cnt);
      end
      m_cond = 0;
      tick();
      checks++;
      if (w_we !== 1'b0 || w_valid !== 1'b1 || retire_cnt !== 32'd3 || w_data !== 32'd0) begin
         errors++;
         $display("FAIL cond_link_not_taken: we=%b valid=%b cnt=%0d data=%h, want 0 1 3 0",
                  w_we, w_valid, retire_cnt, w_data);
      end
      // Always-link overrides an ALU select.
      m_link_mode = 2'b01; m_wb_sel = 2'b00; m_alu = 32'hDEAD; m_pc = 32'hFFFF_FFFC;
      tick();
      checks++;
      if (w_data !== 32'h0000_0004 || w_we !== 1'b1) begin
         errors++;
         $display("FAIL link_always_wrap: data=%h we=%b, want 00000004 1", w_data, w_we);
      end
   endtask

   task automatic test_stall_flush();
      logic [31:0] held_data, held_cnt;
      clear_inputs();
      m_valid = 1; m_regwrite = 1; m_dst = 5; m_wb_sel = 2'b11; m_aux = 32'hCAFE_0001; m_pc = 32'h400;
      tick();
      held_data = 32'hCAFE_0001;
      held_cnt  = exp_cnt;
      for (int i = 0; i < 3; i++) begin
         stall = 1; m_aux = $urandom; m_pc = $urandom; m_dst = 5'($urandom_range(1, 31));
         tick();
         checks++;
         if (w_data !== held_data || w_dst !== 5'd5 || w_pc !== 32'h400 || retire_cnt !== held_cnt) begin
            errors++;
            $display("FAIL stall_hold[%0d]: data=%h dst=%0d pc=%h cnt=%0d, want %h 5 400 %0d",
                     i, w_data, w_dst, w_pc, retire_cnt, held_data, held_cnt);
         end
      end
      flush = 1;
      tick();
      checks++;
      if (w_valid !== 1'b0 || w_we !== 1'b0 || w_data !== 32'd0 || w_pc !== 32'd0 || retire_cnt !== held_cnt) begin
         errors++;
         $display("FAIL stall_flush_bubble: valid=%b we=%b data=%h pc=%h cnt=%0d, want 0 0 0 0 %0d",
                  w_valid, w_we, w_data, w_pc, retire_cnt, held_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_load_ext();
      logic [31:0] want_lb, want_lhu, want_lh;
`ifdef WB_LOAD_EXT_EN
      want_lb = 32'hFFFF_FF80; want_lhu = 32'h0000_80FF; want_lh = 32'hFFFF_80FF;
`else
      want_lb = 32'h80FF_7F01; want_lhu = 32'h80FF_7F01; want_lh = 32'h80FF_7F01;
`endif
      clear_inputs();
      m_valid = 1; m_regwrite = 1; m_dst = 3; m_wb_sel = 2'b01; m_mem = 32'h80FF_7F01;
      m_ld_type = 3'b001; m_addr_lo = 2'd3;
      tick();
      checks++;
      if (w_data !== want_lb) begin
         errors++;
         $display("FAIL load_lb: data=%h want %h", w_data, want_lb);
      end
      m_ld_type = 3'b100; m_addr_lo = 2'd2;
      tick();
      checks++;
      if (w_data !== want_lhu) begin
         errors++;
         $display("FAIL load_lhu: data=%h want %h", w_data, want_lhu);
      end
      m_ld_type = 3'b011; m_addr_lo = 2'd3;
      tick();
      checks++;
      if (w_data !== want_lh) begin
         errors++;
         $display("FAIL load_lh_odd: data=%h want %h", w_data, want_lh);
      end
   endtask

   task automatic test_zero_dst_wrap();
      clear_inputs();
      m_valid = 1; m_regwrite = 1; m_dst = 0; m_alu = 32'h55;
      tick();
      checks++;
      if (w_we !== 1'b0 || w_valid !== 1'b1) begin
         errors++;
         $display("FAIL zero_dst: we=%b valid=%b, want 0 1", w_we, w_valid);
      end
      stall = 1;
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      exp_cnt = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (retire_cnt !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL cnt_preload: cnt=%h want ffffffff", retire_cnt);
      end
      stall = 0;
      tick();
      checks++;
      if (retire_cnt !== 32'd0) begin
         errors++;
         $display("FAIL cnt_wrap: cnt=%h want 0", retire_cnt);
      end
   endtask

   task automatic test_async_reset();
      clear_inputs();
      m_valid = 1; m_regwrite = 1; m_dst = 9; m_alu = 32'hA5A5; m_pc = 32'h800;
      tick();
      checks++;
      if (w_we !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: we=%b want 1", w_we);
      end
      #2 reset = 1'b1;
      model_clear();
      exp_cnt = 0;
      #1;
      checks++;
      if ({w_data, w_dst, w_we, w_pc, w_valid, retire_cnt} !== '0) begin
         errors++;
         $display("FAIL async_reset: data=%h dst=%0d we=%b pc=%h valid=%b cnt=%0d, all should be 0",
                  w_data, w_dst, w_we, w_pc, w_valid, retire_cnt);
      end
      stall = 1; m_alu = 32'h7777;
      @(negedge clk);
      reset = 1'b0;
      tick();
      checks++;
      if (w_valid !== 1'b0 || w_data !== 32'd0 || retire_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_stall: valid=%b data=%h cnt=%0d, want 0 0 0", w_valid, w_data, retire_cnt);
      end
      stall = 0;
      tick();
      checks++;
      if (w_data !== 32'h7777 || w_we !== 1'b1 || retire_cnt !== 32'd1) begin
         errors++;
         $display("FAIL post_reset_capture: data=%h we=%b cnt=%0d, want 7777 1 1", w_data, w_we, retire_cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         m_valid = ($urandom_range(0, 4) != 0);
         m_pc = $urandom; m_alu = $urandom; m_mem = $urandom; m_aux = $urandom;
         m_wb_sel = 2'($urandom); m_link_mode = 2'($urandom); m_cond = 1'($urandom);
         m_dst = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         m_regwrite = 1'($urandom); m_ld_type = 3'($urandom); m_addr_lo = 2'($urandom);
         tick();
         checks++;
         if (w_data !== model_data(e) || w_we !== model_we(e) || w_dst !== e.dst ||
             w_pc !== e.pc || w_valid !== e.valid || retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL random[%0d]: data=%h/%h we=%b/%b dst=%0d/%0d pc=%h/%h valid=%b/%b cnt=%0d/%0d (got/want)",
                     i, w_data, model_data(e), w_we, model_we(e), w_dst, e.dst, w_pc, e.pc,
                     w_valid, e.valid, retire_cnt, exp_cnt);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_cond_link();
      test_stall_flush();
      test_load_ext();
      test_zero_dst_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
